muldiv_sequencer: RTL

- Sequences the shared multiply/divide resources (booth_mult, booth_div) for the multicycle CPU.
- Accepts one-cycle requests from control_Unit and latches the operands from A/B.
- Starts exactly one engine, then waits for its done with a timeout.
- Writes the result into the HI/LO registers, and reports busy, done, divide-by-zero and error status back to the control unit.

---
 rtl/muldiv_sequencer_if.sv | 55 +++++
 rtl/muldiv_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
// Bundles every non-clock signal of the multiply/divide sequencer:
//   - control-unit request side : Use_Mult, Use_Div, RegA_Out, RegB_Out
//   - control-unit status side  : MulDiv_Busy, MulDiv_Done, Div_Zero,
//                                 MulDiv_Error
//   - HI/LO register write side : HI_Load, LO_Load, RegHI_In, RegLO_In
//   - shared engine side        : Op_A, Op_B, mult_start/done/hi/lo,
//                                 div_start/done/hi/lo
// modport master : the sequencer itself (drives starts, operands, HI/LO,
//                  status).
// modport slave  : the surrounding CPU datapath and the two Booth engines.
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if;
    logic        Use_Mult;
    logic        Use_Div;
    logic [31:0] RegA_Out;
    logic [31:0] RegB_Out;
    logic [31:0] Op_A;
    logic [31:0] Op_B;
    logic        mult_start;
    logic        mult_done;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        HI_Load;
    logic        LO_Load;
    logic [31:0] RegHI_In;
    logic [31:0] RegLO_In;
    logic        MulDiv_Busy;
    logic        MulDiv_Done;
    logic        Div_Zero;
    logic        MulDiv_Error;

    modport master (
        input  Use_Mult, Use_Div, RegA_Out, RegB_Out,
        input  mult_done, mult_hi, mult_lo,
        input  div_done, div_hi, div_lo,
        output Op_A, Op_B, mult_start, div_start,
        output HI_Load, LO_Load, RegHI_In, RegLO_In,
        output MulDiv_Busy, MulDiv_Done, Div_Zero, MulDiv_Error
    );

    modport slave (
        output Use_Mult, Use_Div, RegA_Out, RegB_Out,
        output mult_done, mult_hi, mult_lo,
        output div_done, div_hi, div_lo,
        input  Op_A, Op_B, mult_start, div_start,
        input  HI_Load, LO_Load, RegHI_In, RegLO_In,
        input  MulDiv_Busy, MulDiv_Done, Div_Zero, MulDiv_Error
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Sequences the shared booth_mult / booth_div engines for the multicycle CPU.
// A one-cycle request from the control unit latches A/B, starts exactly one
// engine, waits (with a timeout) for its done, then writes the result into
// HI/LO for one cycle and pulses MulDiv_Done.
//
// Ports:
//   clock  - system clock, all state on the rising edge
//   reset  - synchronous, active-high reset
//   bus    - muldiv_sequencer_if.master: request/operands from the control
//            unit, engine start/done/results, HI/LO write port, status
//
// Parameters:
//   TIMEOUT - counter value (from the engine start cycle) at which a run
//             without done is abandoned with MulDiv_Error
//   CNT_W   - run counter width; 2**CNT_W must exceed TIMEOUT
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    muldiv_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        WRITE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_CNT_ZERO = {CNT_W{1'b0}};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_mult_start;
    logic             r_div_start;
    logic             r_load;
    logic             r_done;
    logic             r_div_zero;
    logic             r_req_err;
    logic             r_busy;

    logic             w_in_run;
    logic             w_sel_done;
    logic [31:0]      w_sel_hi;
    logic [31:0]      w_sel_lo;
    logic             w_honour;
    logic             w_timeout;

    // Select the done/result of the engine that owns the current run.
    always_comb begin
        w_in_run   = 1'b0;
        w_sel_done = 1'b0;
        w_sel_hi   = r_hi;
        w_sel_lo   = r_lo;
        case (r_state)
            MULT_RUN: begin
                w_in_run   = 1'b1;
                w_sel_done = bus.mult_done;
                w_sel_hi   = bus.mult_hi;
                w_sel_lo   = bus.mult_lo;
            end
            DIV_RUN: begin
                w_in_run   = 1'b1;
                w_sel_done = bus.div_done;
                w_sel_hi   = bus.div_hi;
                w_sel_lo   = bus.div_lo;
            end
            default: begin
                w_in_run   = 1'b0;
                w_sel_done = 1'b0;
            end
        endcase
    end

    // A done seen in the start cycle (counter 0) belongs to no valid run.
    assign w_honour  = w_in_run & (r_cnt != LP_CNT_ZERO) & w_sel_done;
    // The timeout error must cover the very cycle counter==TIMEOUT, and a done
    // arriving in that same cycle still wins, so this term cannot be registered.
    assign w_timeout = w_in_run & (r_cnt == LP_TIMEOUT) & ~w_sel_done;

    // Sequencer FSM with registered control outputs and result capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= LP_CNT_ZERO;
            r_op_a       <= 32'h0000_0000;
            r_op_b       <= 32'h0000_0000;
            r_hi         <= 32'h0000_0000;
            r_lo         <= 32'h0000_0000;
            r_mult_start <= 1'b0;
            r_div_start  <= 1'b0;
            r_load       <= 1'b0;
            r_done       <= 1'b0;
            r_div_zero   <= 1'b0;
            r_req_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // single-cycle pulses drop unless re-armed below
            r_mult_start <= 1'b0;
            r_div_start  <= 1'b0;
            r_load       <= 1'b0;
            r_done       <= 1'b0;
            r_div_zero   <= 1'b0;
            r_req_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Use_Mult && bus.Use_Div) begin
                        r_req_err <= 1'b1;
                    end else if (bus.Use_Mult) begin
                        r_op_a       <= bus.RegA_Out;
                        r_op_b       <= bus.RegB_Out;
                        r_cnt        <= LP_CNT_ZERO;
                        r_mult_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= MULT_RUN;
                    end else if (bus.Use_Div) begin
                        if (bus.RegB_Out == 32'h0000_0000) begin
                            // rejected up front: operands are not latched
                            r_div_zero <= 1'b1;
                        end else begin
                            r_op_a      <= bus.RegA_Out;
                            r_op_b      <= bus.RegB_Out;
                            r_cnt       <= LP_CNT_ZERO;
                            r_div_start <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= DIV_RUN;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                MULT_RUN, DIV_RUN: begin
                    if (w_honour) begin
                        r_hi    <= w_sel_hi;
                        r_lo    <= w_sel_lo;
                        r_load  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= WRITE;
                    end else if (w_timeout) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_ONE;
                    end
                end
                WRITE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Op_A         = r_op_a;
    assign bus.Op_B         = r_op_b;
    assign bus.mult_start   = r_mult_start;
    assign bus.div_start    = r_div_start;
    assign bus.HI_Load      = r_load;
    assign bus.LO_Load      = r_load;
    assign bus.RegHI_In     = r_hi;
    assign bus.RegLO_In     = r_lo;
    assign bus.MulDiv_Busy  = r_busy;
    assign bus.MulDiv_Done  = r_done;
    assign bus.Div_Zero     = r_div_zero;
    assign bus.MulDiv_Error = r_req_err | w_timeout;

endmodule
